// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// Defines word widths, reset/bubble values, fetch op codes and the IF/ID bundle.
package mips_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        OP_STEP  = 2'd0,
        OP_HOLD  = 2'd1,
        OP_REDIR = 2'd2
    } fetch_op_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc_plus4;
        logic              valid;
    } if_id_t;

    function automatic logic [ADDR_W-1:0] word_align(
        input logic [ADDR_W-1:0] a
    );
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational imem.
// master: drives imem_addr, receives imem_inst; slave: the memory side.
interface if_fetch_stage_if
    import mips_pkg::*;
();

    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_inst;

    modport master (
        output imem_addr,
        input  imem_inst
    );

    modport slave (
        input  imem_addr,
        output imem_inst
    );

endinterface

// File: rtl/if_fetch_stage_pc_reg.sv
// PC register with the redirect / hold / increment next-PC mux.
// Ports: clk, rst_n, stall, branch/jump requests in; pc, pc_plus4, op out.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output fetch_op_t         op
);

    logic              redirect;
    logic              do_redir;
    logic              do_hold;
    logic              do_step;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    assign redirect = branch_taken | jump;

    // One-hot selects: redirect beats stall beats increment.
    assign do_redir = redirect;
    assign do_hold  = ~redirect & stall;
    assign do_step  = ~redirect & ~stall;

    // Branch wins over a simultaneous jump.
    assign target   = branch_taken ? branch_target : jump_target;
    assign pc_plus4 = pc_q + PC_STEP;

    always_comb begin
        pc_d = pc_q;
        op   = OP_HOLD;
        unique case (1'b1)
            do_redir: begin
                pc_d = word_align(target);
                op   = OP_REDIR;
            end
            do_hold: begin
                pc_d = pc_q;
                op   = OP_HOLD;
            end
            do_step: begin
                pc_d = pc_plus4;
                op   = OP_STEP;
            end
            default: begin
                pc_d = pc_q;
                op   = OP_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC, imem addressing, IF/ID register and fetch/stall counters.
// Ports: clk, rst_n, hazard/redirect inputs, imem master bus, IF/ID outputs.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [INST_W-1:0] NOP_INST = mips_pkg::NOP_INST,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    if_fetch_stage_if.master  imem,
    output logic [INST_W-1:0] ifid_inst,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus4,
    output logic              ifid_valid,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    fetch_op_t         op;
    if_id_t            ifid_q;
    logic [CNT_W-1:0]  fetch_q;
    logic [CNT_W-1:0]  stall_q;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .op            (op)
    );

    // imem reads asynchronously, so the address is the PC itself.
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q.inst     <= NOP_INST;
            ifid_q.pc       <= '0;
            ifid_q.pc_plus4 <= '0;
            ifid_q.valid    <= 1'b0;
        end else begin
            unique case (op)
                OP_REDIR: begin
                    // Squash the wrong-path fetch; keep pc fields.
                    ifid_q.inst  <= NOP_INST;
                    ifid_q.valid <= 1'b0;
                end
                OP_STEP: begin
                    ifid_q.inst     <= imem.imem_inst;
                    ifid_q.pc       <= pc;
                    ifid_q.pc_plus4 <= pc_plus4;
                    ifid_q.valid    <= 1'b1;
                end
                default: begin
                    ifid_q <= ifid_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q <= '0;
            stall_q <= '0;
        end else begin
            if (op == OP_STEP) begin
                fetch_q <= fetch_q + CNT_W'(1);
            end
            if (op == OP_HOLD) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign ifid_inst     = ifid_q.inst;
    assign ifid_pc       = ifid_q.pc;
    assign ifid_pc_plus4 = ifid_q.pc_plus4;
    assign ifid_valid    = ifid_q.valid;
    assign fetch_cnt     = fetch_q;
    assign stall_cnt     = stall_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline; the initiator side of the instruction-memory interface.
- Owns the PC, drives the word address into the combinational-read imem, and captures the returned instruction into the IF/ID pipeline register.
- Accepts stall from the hazard unit and branch/jump redirects resolved in ID; inserts bubbles on redirect.
- Keeps two free-running performance counters for fetch and stall accounting.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INST, 32'h00000000, instruction word (sll $0,$0,0) inserted as a bubble.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- branch_taken  in  1  ID resolved a taken branch.
- branch_target  in  32  branch destination.
- jump  in  1  ID resolved j/jal/jr.
- jump_target  in  32  jump destination.
- imem_addr  out  32  byte address to imem; equals the PC, combinational from the PC register.
- imem_inst  in  32  instruction returned by imem in the same cycle (asynchronous read).
- ifid_inst  out  32  IF/ID instruction register.
- ifid_pc  out  32  IF/ID PC of that instruction.
- ifid_pc_plus4  out  32  IF/ID PC+4.
- ifid_valid  out  1  1 = real instruction, 0 = bubble.
- fetch_cnt  out  CNT_W  count of instructions latched with valid=1.
- stall_cnt  out  CNT_W  count of stalled cycles.

Behaviour:
- Reset, asynchronous on rst_n low, takes effect immediately and mid-operation:
  - pc=RESET_PC, so imem_addr=RESET_PC.
  - ifid_inst=NOP_INST, ifid_pc=0, ifid_pc_plus4=0, ifid_valid=0.
  - fetch_cnt=0, stall_cnt=0.
- First valid IF/ID content appears one cycle after rst_n is sampled high at a rising edge.
- Per-edge priority, evaluated in this order:
  - 1. redirect = branch_taken | jump.
  - 2. stall.
  - 3. normal fetch.
- Redirect:
  - pc <= target with bits [1:0] forced to 00. Misaligned targets are silently word-aligned.
  - IF/ID <= bubble: ifid_inst=NOP_INST, ifid_valid=0, ifid_pc and ifid_pc_plus4 hold their previous values. This squashes the wrong-path instruction fetched this cycle.
  - branch_taken beats jump when both are asserted; the target is then branch_target.
  - Redirect overrides a simultaneous stall. The wrong-path fetch is discarded whether or not stall is asserted.
- Stall (no redirect): pc and all IF/ID registers hold; stall_cnt += 1.
- Normal fetch:
  - pc <= pc+4, modulo 2^32: 32'hFFFFFFFC wraps to 0.
  - ifid_inst <= imem_inst, ifid_pc <= pc, ifid_pc_plus4 <= pc+4, ifid_valid <= 1.
  - fetch_cnt += 1.
- Counters wrap silently at 2^CNT_W.
- pc[1:0] is always 00. imem_addr has no registered delay relative to the pc.
- No internal FSM beyond the RESET/RUN distinction implied by rst_n. All state updates only on the rising clk edge when rst_n=1.

Decomposition:
- Shared package mips_pkg:
  - INST_W=32, ADDR_W=32, RESET_PC, NOP_INST.
  - PC_STEP=4.
- Sub-module pc_reg:
  - PC register with next-PC mux (redirect/stall/increment) and alignment masking.
  - if_fetch_stage instantiates pc_reg and holds the IF/ID register plus counters.

Test Plan:
- Reset hold then release:
  - During reset: imem_addr=0x0, ifid_valid=0, ifid_inst=0x00000000.
  - Over 3 edges with imem returning 0x20080001/0x20090002/0x01095020: imem_addr=0x4,0x8,0xC.
  - After the third edge: ifid_pc=0x8, ifid_inst=0x01095020, ifid_valid=1, fetch_cnt=3.
- Stall for 2 cycles at pc=0x8:
  - imem_addr stays 0x8 and IF/ID is unchanged.
  - stall_cnt=2.
  - After release, the next edge gives ifid_pc=0x8 and imem_addr=0xC.
- branch_taken with branch_target=0x50 at pc=0x10:
  - Next cycle imem_addr=0x50, ifid_valid=0, ifid_inst=NOP.
  - One edge later: ifid_pc=0x50, valid=1.
- Jump and branch in the same cycle, plus misalignment:
  - branch_taken=1 (target 0x40) with jump=1 (target 0x80) -> imem_addr=0x40.
  - jump alone with jump_target=0x53 -> imem_addr=0x50.
- Redirect with stall in the same cycle, plus wrap:
  - branch to 0x100 with stall=1 -> pc=0x100, bubble latched, stall_cnt unchanged.
  - pc=0xFFFFFFFC, normal fetch -> imem_addr=0x0.
- Asynchronous reset mid-run at pc=0x24, asserted between clock edges:
  - imem_addr=0x0 and ifid_valid=0 immediately, without a clock edge.
  - Both counters read 0.
